div_sequencer: RTL and testbench
================================

// Module: div_sequencer
// PURPOSE
//  Multi-cycle sequencer for the DIV instruction. The control unit raises no regWrite for DIV.
//  This block instead accepts the operands from ID/EX and runs a restoring divider, 1 quotient bit/cycle.
//  It stalls the pipeline while busy and delivers quotient/remainder (LO/HI) with a 1-cycle done pulse.
//  Sits beside the EX-stage ALU; the hazard unit ORs `stall` into its PC/IF-ID hold.
// PARAMETERS
//  W      32  operand width in bits (>=4)
//  CNT_W  6   iteration counter width; must satisfy 2**CNT_W > W
// PORTS
//  clock        in   1  single system clock, rising edge
//  reset_n      in   1  reset, asynchronous, active-low
//  start        in   1  DIV in EX this cycle (opcode==DIV); sampled only in IDLE
//  signed_op    in   1  1 = signed divide; ignored unless DIV_SIGNED_EN
//  dividend     in   W  rs value, sampled with start
//  divisor      in   W  rt value, sampled with start
//  flush        in   1  IFflush/branch squash: abort current operation
//  busy         out  1  registered; high from cycle after accepted start until done
//  stall        out  1  combinational: (state==IDLE & start) | busy
//  done         out  1  registered; 1-cycle pulse, results valid
//  quotient     out  W  LO result, held until next accepted start
//  remainder    out  W  HI result, held until next accepted start
//  div_by_zero  out  1  registered; valid with done, held like the results
// BEHAVIOUR
//  Interface: one clock; reset is asynchronous and active-low.
//  Reset: state=IDLE; busy, done, div_by_zero = 0; quotient, remainder = 0; counter = 0.
//  States: IDLE -> (start & ~flush) -> RUN; RUN -> (cnt==0) -> [FIX] -> DONE; DONE -> IDLE.
//  IDLE, start: latch operands; cnt = W-1; partial remainder R = 0; Q = dividend.
//  RUN, per cycle: R' = {R[W-2:0],Q[W-1]} - divisor.
//   If the subtraction is non-negative (W+1-bit compare): R = R', shift in 1.
//   Else keep the shifted R, shift in 0. Then cnt -= 1.
//  Divisor==0 at start: skip RUN, go to DONE next cycle.
//   quotient = {W{1'b1}}, remainder = dividend, div_by_zero = 1.
//  Latency: start at cycle 0 -> done high in cycle W+1 (W+2 with DIV_SIGNED_EN); zero-divide: cycle 1.
//  stall drops in the DONE cycle so the dependent instruction advances as done pulses.
//  Start while busy/DONE: ignored (hazard unit guarantees no issue; bench checks no state change).
//  flush in any non-IDLE state: next state IDLE, busy=0, no done pulse, results keep old values.
//  Start & flush same cycle in IDLE: start ignored.
//  Reset mid-operation: immediate IDLE per reset values, no done.
// CONFIGURATION
//  DIV_SIGNED_EN defined: if signed_op, operands are converted to magnitudes at start.
//   FIX state negates quotient if signs differ; remainder takes the dividend's sign.
//   Most-negative / -1 returns quotient = most-negative, remainder = 0.
//   FIX state is always traversed, so latency is uniformly W+2.
//  DIV_SIGNED_EN undefined: unsigned only, signed_op unused, no FIX state, latency W+1.
// STRUCTURE
//  Shared package/include: state encoding (IDLE, RUN, FIX, DONE as 2-bit localparams).
//   The DIV opcode constant is already in the shared opcode include.
//  One sub-module: div_step (combinational shift-subtract of one bit: R, Q, divisor -> R', Q').
//  FSM, counter and sign fixup stay in div_sequencer.
// TESTING
//  100/7 unsigned, W=32 -> done at cycle 33, quotient=14, remainder=2, stall high cycles 0..32.
//  divisor=0, dividend=0x1234 -> done at cycle 1, quotient=0xFFFFFFFF, remainder=0x1234, div_by_zero=1.
//  0xFFFFFFFF/1 -> quotient=0xFFFFFFFF, remainder=0; then 5/10 -> quotient=0, remainder=5.
//  flush at cycle 10 of 100/7 -> IDLE at cycle 11, no done, outputs keep prior values; new start accepted.
//  reset_n low at cycle 5 -> busy=0, quotient=0 asynchronously; start pulse during RUN -> ignored.
//  DIV_SIGNED_EN: -7/2 -> quotient=-3, remainder=-1 at cycle 34; 0x80000000/-1 -> 0x80000000, 0.

Source files
------------

// File: rtl/div_sequencer_pkg.sv
// Shared definitions for the DIV sequencer.
//   state_e            : FSM state encoding (IDLE, RUN, FIX, DONE), 2 bits
//   DIV_W_DEFAULT      : default operand width
//   DIV_CNT_W_DEFAULT  : default iteration counter width (2**CNT_W > W)
package div_sequencer_pkg;

  localparam int DIV_W_DEFAULT     = 32;
  localparam int DIV_CNT_W_DEFAULT = 6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/div_sequencer_if.sv
// Pipeline <-> divider handshake bundle.
//   master : EX-stage side; drives start/signed_op/dividend/divisor/flush,
//            receives busy/stall/done/quotient/remainder/div_by_zero
//   slave  : the div_sequencer itself (opposite directions)
interface div_sequencer_if #(
  parameter int W = 32
);

  logic         start;
  logic         signed_op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         busy;
  logic         stall;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor, flush,
    input  busy, stall, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor, flush,
    output busy, stall, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One iteration of a restoring divider (combinational).
//   r_in    : partial remainder
//   q_in    : dividend/quotient shift register (MSB is the next dividend bit)
//   divisor : divisor magnitude
//   r_out   : next partial remainder
//   q_out   : q_in shifted left with the new quotient bit in the LSB
module div_step #(
  parameter int W = 32
) (
  input  logic [W-1:0] r_in,
  input  logic [W-1:0] q_in,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] r_out,
  output logic [W-1:0] q_out
);

  logic [W:0]   shifted;
  logic [W-1:0] diff;
  logic         fits;

  // The shifted remainder can be W+1 bits wide, so the compare must be too.
  assign shifted = {r_in, q_in[W-1]};
  assign fits    = shifted >= {1'b0, divisor};
  // When fits, the true difference is below the divisor, so W bits hold it.
  assign diff    = shifted[W-1:0] - divisor;
  assign r_out   = fits ? diff : shifted[W-1:0];
  assign q_out   = {q_in[W-2:0], fits};

endmodule

// File: rtl/div_sequencer.sv
// Multi-cycle DIV sequencer: restoring divider, one quotient bit per cycle.
// Stalls the pipeline while busy and delivers LO (quotient) / HI (remainder)
// with a one-cycle done pulse. Define DIV_SIGNED_EN to add signed division
// (magnitude conversion at start, FIX state for sign correction).
//   clock, reset_n : system clock (rising edge), async active-low reset
//   bus (slave)    : start, signed_op, dividend, divisor, flush in;
//                    busy, stall, done, quotient, remainder, div_by_zero out
module div_sequencer
  import div_sequencer_pkg::*;
#(
  parameter int W     = DIV_W_DEFAULT,
  parameter int CNT_W = DIV_CNT_W_DEFAULT
) (
  input logic            clock,
  input logic            reset_n,
  div_sequencer_if.slave bus
);

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [W-1:0]       r_q;
  logic [W-1:0]       q_q;
  logic [W-1:0]       d_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;
  logic [W-1:0]       quot_q;
  logic [W-1:0]       rem_q;

  logic [W-1:0]       dvd_mag;
  logic [W-1:0]       dvs_mag;
  logic [W-1:0]       step_r;
  logic [W-1:0]       step_q;

`ifdef DIV_SIGNED_EN
  logic neg_quot_q;
  logic neg_rem_q;

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic is_signed);
    return (is_signed && v[W-1]) ? -v : v;
  endfunction

  assign dvd_mag = magnitude(bus.dividend, bus.signed_op);
  assign dvs_mag = magnitude(bus.divisor,  bus.signed_op);
`else
  logic unused_signed_op;

  assign unused_signed_op = bus.signed_op;
  assign dvd_mag          = bus.dividend;
  assign dvs_mag          = bus.divisor;
`endif

  div_step #(.W(W)) u_step (
    .r_in    (r_q),
    .q_in    (q_q),
    .divisor (d_q),
    .r_out   (step_r),
    .q_out   (step_q)
  );

  // NOTE: every register below is updated with <= so all of them see the
  // pre-edge values of each other; blocking here would create ordering bugs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the datapath registers are reset too so results read as zero
      // after reset rather than X.
      state  <= ST_IDLE;
      cnt    <= '0;
      r_q    <= '0;
      q_q    <= '0;
      d_q    <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
`ifdef DIV_SIGNED_EN
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
`endif
    end else begin
      // done is a single-cycle pulse: low unless a branch below raises it.
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.flush) begin
            if (bus.divisor == '0) begin
              // Zero divide skips the iterations entirely.
              state  <= ST_DONE;
              done_q <= 1'b1;
              dbz_q  <= 1'b1;
              quot_q <= '1;
              rem_q  <= bus.dividend;
            end else begin
              state  <= ST_RUN;
              busy_q <= 1'b1;
              cnt    <= CNT_W'(W - 1);
              r_q    <= '0;
              q_q    <= dvd_mag;
              d_q    <= dvs_mag;
`ifdef DIV_SIGNED_EN
              neg_quot_q <= bus.signed_op && (bus.dividend[W-1] ^ bus.divisor[W-1]);
              neg_rem_q  <= bus.signed_op && bus.dividend[W-1];
`endif
            end
          end
        end

        ST_RUN: begin
          if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            r_q <= step_r;
            q_q <= step_q;
            cnt <= cnt - 1'b1;
            if (cnt == '0) begin
`ifdef DIV_SIGNED_EN
              state <= ST_FIX;
`else
              state  <= ST_DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              dbz_q  <= 1'b0;
              quot_q <= step_q;
              rem_q  <= step_r;
`endif
            end
          end
        end

`ifdef DIV_SIGNED_EN
        ST_FIX: begin
          if (bus.flush) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            // Most-negative / -1 wraps back to most-negative, remainder 0.
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            dbz_q  <= 1'b0;
            quot_q <= neg_quot_q ? -q_q : q_q;
            rem_q  <= neg_rem_q  ? -r_q : r_q;
          end
        end
`endif

        ST_DONE: state <= ST_IDLE;

        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  // Combinational so the hazard unit holds the pipeline in the start cycle.
  assign bus.stall       = ((state == ST_IDLE) && bus.start) || busy_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Directed self-checking bench for div_sequencer (W = 32).
module tb_div_sequencer;

`ifdef DIV_SIGNED_EN
  localparam int LAT = 34;
`else
  localparam int LAT = 33;
`endif
  localparam int BOUND = 200;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  div_sequencer_if #(.W(32)) bus ();

  div_sequencer #(.W(32), .CNT_W(6)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Step until done or the bound expires; n holds the current cycle index.
  task automatic wait_done(inout int n);
    while (bus.done !== 1'b1 && n < BOUND) begin
      step();
      n++;
    end
  endtask

  // Watch a number of cycles and report how many done pulses were seen.
  task automatic count_done(input int cycles, output int pulses);
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      step();
      if (bus.done === 1'b1) pulses++;
    end
  endtask

  task automatic do_div(input string tag, input logic [31:0] dvd, input logic [31:0] dvs,
                        input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                        input logic edbz, input int elat);
    int n;
    int stall_n;
    bus.dividend  = dvd;
    bus.divisor   = dvs;
    bus.signed_op = sgn;
    bus.start     = 1'b1;
    #1;
    n       = 0;
    stall_n = 0;
    while (bus.done !== 1'b1 && n < BOUND) begin
      if (bus.stall === 1'b1) stall_n++;
      step();
      bus.start = 1'b0;
      n++;
    end
    bus.start = 1'b0;
    check({tag, " latency"},     n,               elat);
    check({tag, " stall_cyc"},   stall_n,         elat);
    check({tag, " quotient"},    bus.quotient,    eq);
    check({tag, " remainder"},   bus.remainder,   er);
    check({tag, " dbz"},         {31'd0, bus.div_by_zero}, {31'd0, edbz});
    check({tag, " stall_done"},  {31'd0, bus.stall}, 32'd0);
    step();
    check({tag, " done_pulse"},  {31'd0, bus.done}, 32'd0);
    check({tag, " idle_busy"},   {31'd0, bus.busy}, 32'd0);
  endtask

  initial begin
    int n;
    int pulses;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    bus.flush     = 1'b0;

    // Reset state
    step();
    step();
    check("rst busy",      {31'd0, bus.busy},        32'd0);
    check("rst done",      {31'd0, bus.done},        32'd0);
    check("rst dbz",       {31'd0, bus.div_by_zero}, 32'd0);
    check("rst stall",     {31'd0, bus.stall},       32'd0);
    check("rst quotient",  bus.quotient,             32'd0);
    check("rst remainder", bus.remainder,            32'd0);
    rst_n = 1'b1;
    step();

    // Main function
    do_div("100/7",     32'd100,        32'd7,          1'b0, 32'd14,         32'd2,          1'b0, LAT);
    do_div("max/1",     32'hFFFF_FFFF,  32'd1,          1'b0, 32'hFFFF_FFFF,  32'd0,          1'b0, LAT);
    do_div("5/10",      32'd5,          32'd10,         1'b0, 32'd0,          32'd5,          1'b0, LAT);
    do_div("max/max",   32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 32'd1,          32'd0,          1'b0, LAT);
    do_div("maxm1/max", 32'hFFFF_FFFE,  32'hFFFF_FFFF,  1'b0, 32'd0,          32'hFFFF_FFFE,  1'b0, LAT);
    do_div("zero_div",  32'h0000_1234,  32'd0,          1'b0, 32'hFFFF_FFFF,  32'h0000_1234,  1'b1, 1);

    // Flush at cycle 10 of 100/7
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 10; i++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    check("flush busy",      {31'd0, bus.busy},        32'd0);
    check("flush stall",     {31'd0, bus.stall},       32'd0);
    check("flush done",      {31'd0, bus.done},        32'd0);
    check("flush quotient",  bus.quotient,             32'hFFFF_FFFF);
    check("flush remainder", bus.remainder,            32'h0000_1234);
    check("flush dbz",       {31'd0, bus.div_by_zero}, 32'd1);
    count_done(40, pulses);
    check("flush no_done",   pulses, 32'd0);
    do_div("after_flush 200/9", 32'd200, 32'd9, 1'b0, 32'd22, 32'd2, 1'b0, LAT);

    // Start and flush together in IDLE: start ignored
    bus.dividend = 32'd77;
    bus.divisor  = 32'd5;
    bus.start    = 1'b1;
    bus.flush    = 1'b1;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    check("sf busy", {31'd0, bus.busy}, 32'd0);
    count_done(40, pulses);
    check("sf no_done",  pulses,       32'd0);
    check("sf quotient", bus.quotient, 32'd22);

    // Start pulse during RUN is ignored
    bus.dividend = 32'd1000;
    bus.divisor  = 32'd3;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    n = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      n++;
    end
    bus.dividend = 32'd50;
    bus.divisor  = 32'd0;
    bus.start    = 1'b1;
    step();
    n++;
    bus.start = 1'b0;
    check("run_start busy", {31'd0, bus.busy}, 32'd1);
    wait_done(n);
    check("run_start latency",   n,             LAT);
    check("run_start quotient",  bus.quotient,  32'd333);
    check("run_start remainder", bus.remainder, 32'd1);
    check("run_start dbz",       {31'd0, bus.div_by_zero}, 32'd0);
    step();

    // Asynchronous reset at cycle 5 of 100/7
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 1; i < 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check("arst busy",      {31'd0, bus.busy}, 32'd0);
    check("arst quotient",  bus.quotient,      32'd0);
    check("arst remainder", bus.remainder,     32'd0);
    check("arst done",      {31'd0, bus.done}, 32'd0);
    step();
    rst_n = 1'b1;
    count_done(40, pulses);
    check("arst no_done", pulses, 32'd0);

`ifdef DIV_SIGNED_EN
    do_div("s -7/2",     32'hFFFF_FFF9, 32'd2,         1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, LAT);
    do_div("s min/-1",   32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0,         1'b0, LAT);
    do_div("s 7/-2",     32'd7,         32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1,         1'b0, LAT);
    do_div("u -7/2",     32'hFFFF_FFF9, 32'd2,         1'b0, 32'h7FFF_FFFC, 32'd1,         1'b0, LAT);
`else
    do_div("signed_op ignored", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'h7FFF_FFFC, 32'd1, 1'b0, LAT);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
